// File: rtl/seg_scan_controller_if.sv
// Display-side bundle of the seven-segment scan controller: staged load
// inputs toward the controller, per-digit drive back out.
interface seg_scan_controller_if;
  logic [31:0] digit_data;
  logic [7:0]  digit_en;
  logic [7:0]  dp;
  logic        load;
  logic        load_ack;
  logic [3:0]  bin;
  logic        dp_out;
  logic [2:0]  digit_sel;
  logic [7:0]  anode;

  modport master (
    output digit_data, digit_en, dp, load,
    input  load_ack, bin, dp_out, digit_sel, anode
  );

  modport slave (
    input  digit_data, digit_en, dp, load,
    output load_ack, bin, dp_out, digit_sel, anode
  );
endinterface

// File: rtl/seg_scan_controller.sv
// Eight-digit common-anode scan controller: BLANK/DRIVE visit per digit,
// double-buffered contents swapped only at the 7->0 frame boundary.
module seg_scan_controller #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  seg_scan_controller_if.slave  bus
);
  localparam int NUM_DIG = 8;
  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic {BLANK, DRIVE} state_e;

  typedef struct packed {
    logic [4*NUM_DIG-1:0] data;
    logic [NUM_DIG-1:0]   en;
    logic [NUM_DIG-1:0]   dp;
  } disp_t;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         idx_q, idx_d;
  disp_t              act_q, act_d;
  disp_t              stg_q, stg_d;
  logic               pend_q, pend_d;
  logic [NUM_DIG-1:0] anode_q, anode_d;
  logic [3:0]         bin_q, bin_d;
  logic               dpo_q, dpo_d;
  logic [2:0]         sel_q, sel_d;
  logic               ack_q, ack_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
      act_q   <= '0;
      stg_q   <= '0;
      pend_q  <= 1'b0;
      anode_q <= '1;
      bin_q   <= '0;
      dpo_q   <= 1'b0;
      sel_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      act_q   <= act_d;
      stg_q   <= stg_d;
      pend_q  <= pend_d;
      anode_q <= anode_d;
      bin_q   <= bin_d;
      dpo_q   <= dpo_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    act_d   = act_q;
    stg_d   = stg_q;
    pend_d  = pend_q;
    anode_d = anode_q;
    bin_d   = bin_q;
    dpo_d   = dpo_q;
    sel_d   = sel_q;
    ack_d   = 1'b0;

    case (state_q)
      BLANK: begin
        if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
          state_d        = DRIVE;
          cnt_d          = '0;
          anode_d        = '1;
          anode_d[idx_q] = ~act_q.en[idx_q];
        end
      end
      DRIVE: begin
        if (cnt_q == CW'(REFRESH_DIV - 1)) begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = idx_q + 3'd1;
          anode_d = '1;
          if (idx_q == 3'd7 && pend_q) begin
            act_d  = stg_q;
            pend_d = 1'b0;
            ack_d  = 1'b1;
          end
          // Digit-select side updates a whole blank interval ahead of the anode.
          sel_d = idx_d;
          bin_d = act_d.data[{idx_d, 2'b00} +: 4];
          dpo_d = act_d.dp[idx_d];
        end
      end
      default: begin
        state_d = BLANK;
        cnt_d   = '0;
        anode_d = '1;
      end
    endcase

    // Evaluated after the swap so a load on the boundary cycle stays pending.
    if (bus.load) begin
      stg_d.data = bus.digit_data;
      stg_d.en   = bus.digit_en;
      stg_d.dp   = bus.dp;
      pend_d     = 1'b1;
    end
  end

  assign bus.anode     = anode_q;
  assign bus.bin       = bin_q;
  assign bus.dp_out    = dpo_q;
  assign bus.digit_sel = sel_q;
  assign bus.load_ack  = ack_q;
endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller with a short scan (4 drive, 2 blank clocks).
module tb_seg_scan_controller;
  localparam int R     = 4;
  localparam int B     = 2;
  localparam int VISIT = R + B;
  localparam int FRAME = 8 * VISIT;

  typedef struct packed {
    logic [7:0] anode;
    logic [3:0] bin;
    logic       dp_out;
    logic [2:0] sel;
    logic       ack;
  } out_t;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  en;
    logic [7:0]  dp;
    logic [7:0]  exp_lit;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  seg_scan_controller_if bus();

  seg_scan_controller #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  int          ack_cnt = 0;
  logic [7:0]  lit_mask = '0;
  out_t        sb[$];

  // reference state, position-in-frame based
  int          m_t = 0;
  logic [31:0] m_act_data = '0, m_stg_data = '0;
  logic [7:0]  m_act_en = '0, m_stg_en = '0, m_act_dp = '0, m_stg_dp = '0;
  logic        m_pend = 1'b0, m_ack = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic out_t exp_out();
    out_t e;
    int   p, d;
    e       = '0;
    e.anode = 8'hFF;
    if (!rst_n) return e;
    p        = m_t % FRAME;
    d        = p / VISIT;
    e.sel    = 3'(d);
    e.bin    = m_act_data[d*4 +: 4];
    e.dp_out = m_act_dp[d];
    e.ack    = m_ack;
    if ((p % VISIT) >= B) e.anode[d] = ~m_act_en[d];
    return e;
  endfunction

  task automatic model_clear();
    m_t = 0; m_pend = 0; m_ack = 0;
    m_act_data = '0; m_act_en = '0; m_act_dp = '0;
    m_stg_data = '0; m_stg_en = '0; m_stg_dp = '0;
  endtask

  // One clock: model advances at the rising edge, expectation is queued,
  // then popped and compared against the DUT on the falling edge.
  task automatic cyc();
    out_t e, a;
    @(posedge clk);
    if (rst_n) begin
      m_ack = 1'b0;
      if ((m_t % FRAME) == FRAME - 1 && m_pend) begin
        m_act_data = m_stg_data; m_act_en = m_stg_en; m_act_dp = m_stg_dp;
        m_pend = 1'b0;
        m_ack  = 1'b1;
      end
      if (bus.load) begin
        m_stg_data = bus.digit_data; m_stg_en = bus.digit_en; m_stg_dp = bus.dp;
        m_pend = 1'b1;
      end
      m_t++;
    end
    sb.push_back(exp_out());
    @(negedge clk);
    e = sb.pop_front();
    a = '{bus.anode, bus.bin, bus.dp_out, bus.digit_sel, bus.load_ack};
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL outputs pos=%0d: got anode=%h bin=%h dp=%b sel=%0d ack=%b, want anode=%h bin=%h dp=%b sel=%0d ack=%b",
               m_t % FRAME, a.anode, a.bin, a.dp_out, a.sel, a.ack,
               e.anode, e.bin, e.dp_out, e.sel, e.ack);
    end
    lit_mask |= ~bus.anode;
    if (bus.load_ack === 1'b1) ack_cnt++;
    bus.load = 1'b0;
  endtask

  task automatic apply_reset(int n);
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("async_anode_off", 32'(bus.anode), 32'hFF);
    repeat (n) cyc();
    rst_n = 1'b1;
  endtask

  task automatic wait_pos(int p);
    for (int k = 0; k <= FRAME; k++) begin
      if ((m_t % FRAME) == p) return;
      cyc();
    end
  endtask

  task automatic wait_ack();
    for (int k = 0; k < 2 * FRAME + 2; k++) begin
      cyc();
      if (bus.load_ack === 1'b1) return;
    end
    n_chk++;
    n_err++;
    $display("FAIL ack_timeout: got no load_ack, want one within %0d clocks", 2 * FRAME + 2);
  endtask

  task automatic drive_load(logic [31:0] d, logic [7:0] en, logic [7:0] dp);
    bus.digit_data = d;
    bus.digit_en   = en;
    bus.dp         = dp;
    bus.load       = 1'b1;
  endtask

  initial begin
    vec_t vecs[4];
    int   a0;
    vecs[0] = '{32'h76543210, 8'hFF, 8'h01, 8'hFF};
    vecs[1] = '{32'h89ABCDEF, 8'hAA, 8'h80, 8'hAA};
    vecs[2] = '{32'h12345678, 8'h00, 8'hFF, 8'h00};
    vecs[3] = '{32'hFEDCBA98, 8'h55, 8'h0F, 8'h55};

    bus.digit_data = '0;
    bus.digit_en   = '0;
    bus.dp         = '0;
    bus.load       = 1'b0;
    #2;

    // idle after reset: everything dark, no ack
    apply_reset(3);
    a0 = ack_cnt;
    repeat (FRAME) cyc();
    chk("idle_no_ack", 32'(ack_cnt - a0), 32'd0);

    // table: load, wait for the swap, then observe which anodes light
    apply_reset(2);
    for (int i = 0; i < 4; i++) begin
      repeat (5 + i * 7) cyc();
      drive_load(vecs[i].data, vecs[i].en, vecs[i].dp);
      cyc();
      wait_ack();
      lit_mask = '0;
      repeat (FRAME) cyc();
      chk($sformatf("lit_mask_v%0d", i), 32'(lit_mask), 32'(vecs[i].exp_lit));
    end

    // two loads in one frame: only the last applies, one ack
    wait_pos(10);
    a0 = ack_cnt;
    drive_load(32'hAAAA_AAAA, 8'hFF, 8'h00);
    cyc();
    wait_pos(20);
    drive_load(32'h0123_4567, 8'hFF, 8'hF0);
    cyc();
    wait_ack();
    repeat (FRAME) cyc();
    chk("double_load_acks", 32'(ack_cnt - a0), 32'd1);

    // load on the boundary cycle while another is pending
    wait_pos(5);
    a0 = ack_cnt;
    drive_load(32'hBBBB_BBBB, 8'hFF, 8'h0F);
    cyc();
    wait_pos(FRAME - 1);
    drive_load(32'hCCCC_CCCC, 8'hFF, 8'hF0);
    cyc();
    repeat (FRAME + 2) cyc();
    chk("boundary_load_acks", 32'(ack_cnt - a0), 32'd2);

    // reset while digit 3 is lit
    wait_pos(3 * VISIT + B + 1);
    chk("digit3_lit", 32'(bus.anode), 32'hF7);
    a0 = ack_cnt;
    apply_reset(3);
    repeat (FRAME + 12) cyc();
    chk("post_reset_no_ack", 32'(ack_cnt - a0), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
